// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcode values,
// RET subcodes and the interrupt priority encoder.
package pc_seq_pkg;

  typedef logic [3:0] opcode_t;

  // Operation codes. Codes 4 and 9..15 are not listed here and hold the PC.
  localparam opcode_t OP_NOP  = 4'd0;
  localparam opcode_t OP_JEQ  = 4'd1;
  localparam opcode_t OP_JGT  = 4'd2;
  localparam opcode_t OP_JLT  = 4'd3;
  localparam opcode_t OP_JMP  = 4'd5;
  localparam opcode_t OP_NEX  = 4'd6;
  localparam opcode_t OP_CALL = 4'd7;
  localparam opcode_t OP_RET  = 4'd8;

  // RET subcodes carried in the target field. Any other value is a real
  // return that pops the stack.
  localparam int RET_IE_SET = 1;
  localparam int RET_IE_CLR = 2;

  // Widest request vector the priority encoder accepts.
  localparam int PENC_MAX_W = 32;

  // Returns the index of the lowest set bit, which is the highest-priority
  // request. Returns 0 when nothing is set; callers qualify with |req.
  function automatic int unsigned lowest_set_index(input logic [PENC_MAX_W-1:0] req);
    int unsigned idx;
    idx = 0;
    for (int i = PENC_MAX_W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Parametrised LIFO holding return addresses for CALL and interrupt entry.
// Only the entry count is reset; the storage array is don't-care after reset
// because every slot is written before it becomes visible through 'top'.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 15,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic             eff_pop;
  logic             eff_push;

  // With DEPTH a power of two, the low bits of the count address the next
  // free slot, and one less addresses the current top (wrapping correctly
  // when the stack is full).
  assign wr_ptr  = count[PTR_W-1:0];
  assign top_ptr = count[PTR_W-1:0] - PTR_W'(1);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop of an empty stack is ignored. A push onto a full stack is only
  // accepted when a pop frees the top slot in the same cycle.
  assign eff_pop  = pop & ~empty;
  assign eff_push = push & (~full | eff_pop);

  // Top of stack read straight from the registered array, so a value pushed
  // on one edge is visible right after it and a following pop sees it too.
  assign top = empty ? '0 : mem[top_ptr];

  // Entry count: push and pop together replace the top and leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (eff_push && !eff_pop) begin
      count <= count + CNT_W'(1);
    end else if (eff_pop && !eff_push) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage writes: a simultaneous push/pop overwrites the current top,
  // a plain push fills the next free slot.
  always_ff @(posedge clk) begin
    if (eff_push && eff_pop) begin
      mem[top_ptr] <= din;
    end else if (eff_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_seq.sv
// Program-counter sequencer: conditional/unconditional jumps, CALL/RET via an
// internal return stack, and prioritised vectored interrupts with one level
// of ISR tracking. Stack overflow/underflow vector to a trap address and set
// sticky flags that only reset clears.
module pc_stack_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int STACK_DEPTH = 16,
  parameter int NUM_IRQ     = 3,
  parameter int VEC_BASE    = 2,
  parameter int TRAP_ADDR   = 1,
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1,
  localparam int IRQ_ID_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [3:0]          op,
  input  logic [ADDR_W-1:0]   target,
  input  logic [ADDR_W-1:0]   reg_target,
  input  logic                eq,
  input  logic                lt,
  input  logic                gt,
  input  logic                aeq,
  input  logic                hlt,
  input  logic [NUM_IRQ-1:0]  irq,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   ret_addr,
  output logic [SP_W-1:0]     sp,
  output logic                ie,
  output logic                in_isr,
  output logic                irq_ack,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic                stk_ovf,
  output logic                stk_unf
);

  // Stack interface
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_din;
  logic [ADDR_W-1:0] stk_top;
  logic [SP_W-1:0]   stk_count;
  logic              stk_full;
  logic              stk_empty;

  // Next-state values
  logic [ADDR_W-1:0]   pc_n;
  logic                ie_n;
  logic                in_isr_n;
  logic [SP_W-1:0]     isr_sp_n;
  logic                irq_ack_n;
  logic [IRQ_ID_W-1:0] irq_id_n;
  logic                stk_ovf_n;
  logic                stk_unf_n;

  // Stack depth recorded at ISR entry; the RET that brings the stack back
  // through this depth is the one that leaves the ISR.
  logic [SP_W-1:0] isr_sp;

  // Decode helpers
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jump_tgt;
  logic                cmp_aeq;
  logic                irq_take;
  logic [IRQ_ID_W-1:0] irq_k;
  logic [ADDR_W-1:0]   irq_vec;
  logic                is_ie_set;
  logic                is_ie_clr;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .top   (stk_top),
    .count (stk_count),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign sp       = stk_count;
  assign ret_addr = stk_top;

  assign pc_inc    = pc + ADDR_W'(1);
  assign jump_tgt  = (target == '0) ? reg_target : target;
  assign cmp_aeq   = aeq & eq;
  assign is_ie_set = (target == ADDR_W'(RET_IE_SET));
  assign is_ie_clr = (target == ADDR_W'(RET_IE_CLR));

  // An interrupt needs a free stack slot; with a full stack it simply waits
  // and the current opcode runs as if no request were pending.
  assign irq_take = step & (|irq) & ie & ~in_isr & ~stk_full;
  assign irq_k    = IRQ_ID_W'(lowest_set_index(PENC_MAX_W'(irq)));
  assign irq_vec  = ADDR_W'(VEC_BASE) + ADDR_W'(irq_k);

  // Next-state decode: interrupt entry overrides the opcode, otherwise the
  // opcode selects the new PC and any stack/enable side effects.
  always_comb begin
    pc_n      = pc;
    ie_n      = ie;
    in_isr_n  = in_isr;
    isr_sp_n  = isr_sp;
    irq_ack_n = 1'b0;
    irq_id_n  = irq_id;
    stk_ovf_n = stk_ovf;
    stk_unf_n = stk_unf;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = pc_inc;

    if (irq_take) begin
      stk_push  = 1'b1;
      stk_din   = (op == OP_NEX) ? pc_inc : pc;
      pc_n      = irq_vec;
      in_isr_n  = 1'b1;
      isr_sp_n  = stk_count + SP_W'(1);
      irq_ack_n = 1'b1;
      irq_id_n  = irq_k;
    end else if (step) begin
      case (op)
        OP_JEQ: pc_n = (eq | cmp_aeq) ? jump_tgt : pc_inc;
        OP_JGT: pc_n = (gt | cmp_aeq) ? jump_tgt : pc_inc;
        OP_JLT: pc_n = (lt | cmp_aeq) ? jump_tgt : pc_inc;
        OP_JMP: pc_n = jump_tgt;
        OP_NEX: pc_n = hlt ? pc : pc_inc;
        OP_CALL: begin
          if (stk_full) begin
            pc_n      = ADDR_W'(TRAP_ADDR);
            stk_ovf_n = 1'b1;
          end else begin
            stk_push = 1'b1;
            stk_din  = pc_inc;
            pc_n     = jump_tgt;
          end
        end
        OP_RET: begin
          if (is_ie_set) begin
            ie_n = 1'b1;
            pc_n = pc_inc;
          end else if (is_ie_clr) begin
            ie_n = 1'b0;
            pc_n = pc_inc;
          end else if (stk_empty) begin
            pc_n      = ADDR_W'(TRAP_ADDR);
            stk_unf_n = 1'b1;
          end else begin
            stk_pop = 1'b1;
            pc_n    = stk_top;
            if (in_isr && (stk_count == isr_sp)) begin
              in_isr_n = 1'b0;
            end
          end
        end
        default: pc_n = pc;
      endcase
    end
  end

  // Architectural state registers; reset wins over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ie      <= 1'b1;
      in_isr  <= 1'b0;
      isr_sp  <= '0;
      irq_ack <= 1'b0;
      irq_id  <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      pc      <= pc_n;
      ie      <= ie_n;
      in_isr  <= in_isr_n;
      isr_sp  <= isr_sp_n;
      irq_ack <= irq_ack_n;
      irq_id  <= irq_id_n;
      stk_ovf <= stk_ovf_n;
      stk_unf <= stk_unf_n;
    end
  end

endmodule

// File: tb/tb_pc_stack_seq.sv
// Scoreboard bench for pc_stack_seq with a 4-entry stack. Each directed
// vector pushes its hand-computed post-edge state into a queue; a monitor
// pops one entry per applied edge and compares on the falling edge.
module tb_pc_stack_seq;
  import pc_seq_pkg::*;

  localparam int ADDR_W = 15;
  localparam int DEPTH  = 4;
  localparam int NIRQ   = 3;

  logic              clk;
  logic              rst;
  logic              step;
  logic [3:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] reg_target;
  logic              eq, lt, gt, aeq;
  logic              hlt;
  logic [NIRQ-1:0]   irq;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_addr;
  logic [2:0]        sp;
  logic              ie;
  logic              in_isr;
  logic              irq_ack;
  logic [1:0]        irq_id;
  logic              stk_ovf;
  logic              stk_unf;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        sp;
    logic [ADDR_W-1:0] ret;
    logic              ie;
    logic              isr;
    logic              ack;
    logic [1:0]        id;
    logic              ovf;
    logic              unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_busy = 0;

  pc_stack_seq #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .NUM_IRQ     (NIRQ),
    .VEC_BASE    (2),
    .TRAP_ADDR   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .op         (op),
    .target     (target),
    .reg_target (reg_target),
    .eq         (eq),
    .lt         (lt),
    .gt         (gt),
    .aeq        (aeq),
    .hlt        (hlt),
    .irq        (irq),
    .pc         (pc),
    .ret_addr   (ret_addr),
    .sp         (sp),
    .ie         (ie),
    .in_isr     (in_isr),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus process
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string vec, input string fld,
                             input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", vec, fld, act, expv);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of inputs just after a rising edge and queue the state
  // expected after the next rising edge.
  task automatic applyStimulus(
    input string name, input bit r, input bit s, input logic [3:0] o,
    input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] rt,
    input logic [3:0] f, input bit h, input logic [2:0] iq,
    input logic [ADDR_W-1:0] e_pc, input logic [2:0] e_sp,
    input logic [ADDR_W-1:0] e_ret, input bit e_ie, input bit e_isr,
    input bit e_ack, input logic [1:0] e_id, input bit e_ovf, input bit e_unf);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    step       = s;
    op         = o;
    target     = t;
    reg_target = rt;
    {eq, lt, gt, aeq} = f;
    hlt        = h;
    irq        = iq;
    e.name = name; e.pc = e_pc; e.sp = e_sp; e.ret = e_ret; e.ie = e_ie;
    e.isr = e_isr; e.ack = e_ack; e.id = e_id; e.ovf = e_ovf; e.unf = e_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: one queued expectation per applied edge, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        mon_busy = 1;
        e = exp_q.pop_front();
        @(negedge clk);
        checkOutput(e.name, "pc",       32'(pc),       32'(e.pc));
        checkOutput(e.name, "sp",       32'(sp),       32'(e.sp));
        checkOutput(e.name, "ret_addr", 32'(ret_addr), 32'(e.ret));
        checkOutput(e.name, "ie",       32'(ie),       32'(e.ie));
        checkOutput(e.name, "in_isr",   32'(in_isr),   32'(e.isr));
        checkOutput(e.name, "irq_ack",  32'(irq_ack),  32'(e.ack));
        checkOutput(e.name, "irq_id",   32'(irq_id),   32'(e.id));
        checkOutput(e.name, "stk_ovf",  32'(stk_ovf),  32'(e.ovf));
        checkOutput(e.name, "stk_unf",  32'(stk_unf),  32'(e.unf));
        mon_busy = 0;
      end
    end
  end

  // Directed vectors. Flags are {eq, lt, gt, aeq}.
  // Columns after the inputs: pc, sp, ret_addr, ie, in_isr, irq_ack, irq_id, ovf, unf
  initial begin
    rst = 1'b0; step = 1'b0; op = OP_NOP; target = '0; reg_target = '0;
    eq = 1'b0; lt = 1'b0; gt = 1'b0; aeq = 1'b0; hlt = 1'b0; irq = '0;
    $display("[TB] starting pc_stack_seq directed run");

    // Reset and sequential stepping, hold on hlt, step low, undefined opcode
    applyStimulus("reset",   1,1,OP_NEX, 0,0,4'b0000,0,3'b000, 15'd0,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("nex1",    0,1,OP_NEX, 0,0,4'b0000,0,3'b000, 15'd1,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("nex2",    0,1,OP_NEX, 0,0,4'b0000,0,3'b000, 15'd2,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("nex3",    0,1,OP_NEX, 0,0,4'b0000,0,3'b000, 15'd3,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("nex4",    0,1,OP_NEX, 0,0,4'b0000,0,3'b000, 15'd4,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("nex_hlt", 0,1,OP_NEX, 0,0,4'b0000,1,3'b000, 15'd4,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("no_step", 0,0,OP_JMP, 7,0,4'b0000,0,3'b001, 15'd4,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("bad_op",  0,1,4'd4,   7,0,4'b0000,0,3'b000, 15'd4,3'd0,15'd0,1,0,0,2'd0,0,0);

    // CALL / RET round trip
    applyStimulus("jmp10",   0,1,OP_JMP, 15'd10,0,4'b0000,0,3'b000,   15'd10,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("call40",  0,1,OP_CALL,15'h40,0,4'b0000,0,3'b000,   15'h40,3'd1,15'd11,1,0,0,2'd0,0,0);
    applyStimulus("ret0",    0,1,OP_RET, 15'd0, 0,4'b0000,0,3'b000,   15'd11,3'd0,15'd0,1,0,0,2'd0,0,0);

    // Interrupt entry on NEX, nested request ignored, return clears in_isr
    applyStimulus("jmp20",   0,1,OP_NEX, 0,0,4'b0000,0,3'b000,        15'd12,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jmp20b",  0,1,OP_JMP, 15'd20,0,4'b0000,0,3'b000,   15'd20,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("irq_take",0,1,OP_NEX, 0,0,4'b0000,0,3'b110,        15'd3,3'd1,15'd21,1,1,1,2'd1,0,0);
    applyStimulus("isr_nest",0,1,OP_NEX, 0,0,4'b0000,0,3'b111,        15'd4,3'd1,15'd21,1,1,0,2'd1,0,0);
    applyStimulus("isr_ret", 0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'd21,3'd0,15'd0,1,0,0,2'd1,0,0);
    // Interrupt over a JMP pushes the current pc and discards the jump
    applyStimulus("irq_jmp", 0,1,OP_JMP, 15'h30,0,4'b0000,0,3'b001,   15'd2,3'd1,15'd21,1,1,1,2'd0,0,0);
    applyStimulus("isr_ret2",0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'd21,3'd0,15'd0,1,0,0,2'd0,0,0);

    // Fill the stack, overflow, deferred interrupt, then drain
    applyStimulus("call1",   0,1,OP_CALL,15'h100,0,4'b0000,0,3'b000,  15'h100,3'd1,15'd22,1,0,0,2'd0,0,0);
    applyStimulus("call2",   0,1,OP_CALL,15'h200,0,4'b0000,0,3'b000,  15'h200,3'd2,15'h101,1,0,0,2'd0,0,0);
    applyStimulus("call3",   0,1,OP_CALL,15'h300,0,4'b0000,0,3'b000,  15'h300,3'd3,15'h201,1,0,0,2'd0,0,0);
    applyStimulus("call4",   0,1,OP_CALL,15'h400,0,4'b0000,0,3'b000,  15'h400,3'd4,15'h301,1,0,0,2'd0,0,0);
    applyStimulus("call_ovf",0,1,OP_CALL,15'h500,0,4'b0000,0,3'b000,  15'd1,3'd4,15'h301,1,0,0,2'd0,1,0);
    applyStimulus("irq_full",0,1,OP_NEX, 0,0,4'b0000,0,3'b001,        15'd2,3'd4,15'h301,1,0,0,2'd0,1,0);
    applyStimulus("pop1",    0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'h301,3'd3,15'h201,1,0,0,2'd0,1,0);
    applyStimulus("pop2",    0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'h201,3'd2,15'h101,1,0,0,2'd0,1,0);
    applyStimulus("pop3",    0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'h101,3'd1,15'd22,1,0,0,2'd0,1,0);
    applyStimulus("pop4",    0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'd22,3'd0,15'd0,1,0,0,2'd0,1,0);

    // Underflow, then reset clears both sticky flags
    applyStimulus("ret_unf", 0,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'd1,3'd0,15'd0,1,0,0,2'd0,1,1);
    applyStimulus("rst2",    1,1,OP_RET, 0,0,4'b0000,0,3'b000,        15'd0,3'd0,15'd0,1,0,0,2'd0,0,0);

    // Conditional branches, register target, interrupt enable control
    applyStimulus("jeq_nt",  0,1,OP_JEQ, 15'h50,0,4'b0000,0,3'b000,   15'd1,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jeq_t",   0,1,OP_JEQ, 15'h50,0,4'b1000,0,3'b000,   15'h50,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jgt_aeq", 0,1,OP_JGT, 15'h60,0,4'b1001,0,3'b000,   15'h60,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jlt_nt",  0,1,OP_JLT, 15'h70,0,4'b0010,0,3'b000,   15'h61,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jlt_t",   0,1,OP_JLT, 15'h70,0,4'b0100,0,3'b000,   15'h70,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("jmp_reg", 0,1,OP_JMP, 15'd0,15'h123,4'b0000,0,3'b000, 15'h123,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("ie_clr",  0,1,OP_RET, 15'd2,0,4'b0000,0,3'b000,    15'h124,3'd0,15'd0,0,0,0,2'd0,0,0);
    applyStimulus("irq_mask",0,1,OP_NEX, 0,0,4'b0000,0,3'b001,        15'h125,3'd0,15'd0,0,0,0,2'd0,0,0);
    applyStimulus("ie_set",  0,1,OP_RET, 15'd1,0,4'b0000,0,3'b000,    15'h126,3'd0,15'd0,1,0,0,2'd0,0,0);
    applyStimulus("irq2",    0,1,OP_NEX, 0,0,4'b0000,0,3'b100,        15'd4,3'd1,15'h127,1,1,1,2'd2,0,0);
    applyStimulus("jmp_top", 0,1,OP_JMP, 15'h7FFF,0,4'b0000,0,3'b000, 15'h7FFF,3'd1,15'h127,1,1,0,2'd2,0,0);
    applyStimulus("pc_wrap", 0,1,OP_NEX, 0,0,4'b0000,0,3'b000,        15'd0,3'd1,15'h127,1,1,0,2'd2,0,0);
    applyStimulus("rst_isr", 1,1,OP_NEX, 0,0,4'b0000,0,3'b000,        15'd0,3'd0,15'd0,1,0,0,2'd0,0,0);

    // Idle and wait a bounded time for the monitor to drain the queue
    @(posedge clk);
    #1;
    rst = 1'b0;
    step = 1'b0;
    irq = '0;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || mon_busy); i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0 || mon_busy) begin
      n_checks++;
      $display("[TB] FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
